// File: rtl/gpu_raster_engine.sv
//------------------------------------------------------------------------------
// gpu_raster_engine : row-major FILL / XOR / COPY rectangle engine on a pixel RAM port.
// Optional GPU_RASTER_CLIP_EN: clamp regions to the screen instead of rejecting them.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gpu_raster_engine #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int XW     = 9,
    parameter int YW     = 8,
    parameter int PW     = 1,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y1,
    input  logic [XW-1:0] cmd_x2,
    input  logic [YW-1:0] cmd_y2,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [PW-1:0] cmd_value,
    output logic [XW-1:0] mem_x,
    output logic [YW-1:0] mem_y,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [PW-1:0] mem_wr_data,
    input  logic [PW-1:0] mem_rd_data,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [1:0]    OP_FILL  = 2'b00;
    localparam logic [1:0]    OP_XOR   = 2'b01;
    localparam logic [1:0]    OP_COPY  = 2'b10;
    localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
    localparam logic [XW:0]   W_C      = (XW+1)'(WIDTH);
    localparam logic [YW:0]   H_C      = (YW+1)'(HEIGHT);
    localparam logic [XW:0]   X_ONE    = (XW+1)'(1);
    localparam logic [YW:0]   Y_ONE    = (YW+1)'(1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [PW-1:0] val_q, val_d;
    logic [PW-1:0] rd_cap_q, rd_cap_d;
    logic [XW-1:0] src_x_q, src_x_d, dst_x_q, dst_x_d, last_x_q, last_x_d, off_x_q, off_x_d;
    logic [YW-1:0] src_y_q, src_y_d, dst_y_q, dst_y_d, last_y_q, last_y_d, off_y_q, off_y_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // Acceptance check, widened by one bit so coordinate sums cannot wrap.
    logic [XW:0]   x1_e, x2_e, w_e, span_w, last_w;
    logic [YW:0]   y1_e, y2_e, h_e, span_h, last_h;
    logic [XW-1:0] base_dx;
    logic [YW-1:0] base_dy;
    logic          cmd_ok, cmd_empty;
`ifdef GPU_RASTER_CLIP_EN
    logic [XW:0]   x2_clip, room_x1, room_x2;
    logic [YW:0]   y2_clip, room_y1, room_y2;
`endif

    always_comb begin
        x1_e      = {1'b0, cmd_x1};
        x2_e      = {1'b0, cmd_x2};
        w_e       = {1'b0, cmd_w};
        y1_e      = {1'b0, cmd_y1};
        y2_e      = {1'b0, cmd_y2};
        h_e       = {1'b0, cmd_h};
        span_w    = '0;
        span_h    = '0;
        cmd_ok    = 1'b0;
        cmd_empty = 1'b0;
        base_dx   = cmd_x1;
        base_dy   = cmd_y1;
`ifdef GPU_RASTER_CLIP_EN
        x2_clip = (x2_e >= W_C) ? W_C - X_ONE : x2_e;
        y2_clip = (y2_e >= H_C) ? H_C - Y_ONE : y2_e;
        room_x1 = (x1_e >= W_C) ? '0 : W_C - x1_e;
        room_x2 = (x2_e >= W_C) ? '0 : W_C - x2_e;
        room_y1 = (y1_e >= H_C) ? '0 : H_C - y1_e;
        room_y2 = (y2_e >= H_C) ? '0 : H_C - y2_e;
`endif
        case (cmd_op)
            OP_FILL, OP_XOR: begin
`ifdef GPU_RASTER_CLIP_EN
                cmd_ok    = 1'b1;
                cmd_empty = (x1_e > x2_clip) || (y1_e > y2_clip);
                span_w    = x2_clip - x1_e + X_ONE;
                span_h    = y2_clip - y1_e + Y_ONE;
`else
                cmd_ok = (x1_e <= x2_e) && (x2_e < W_C) && (y1_e <= y2_e) && (y2_e < H_C);
                span_w = x2_e - x1_e + X_ONE;
                span_h = y2_e - y1_e + Y_ONE;
`endif
            end
            OP_COPY: begin
                base_dx = cmd_x2;
                base_dy = cmd_y2;
`ifdef GPU_RASTER_CLIP_EN
                span_w = w_e;
                if (room_x1 < span_w) span_w = room_x1;
                if (room_x2 < span_w) span_w = room_x2;
                span_h = h_e;
                if (room_y1 < span_h) span_h = room_y1;
                if (room_y2 < span_h) span_h = room_y2;
                cmd_ok    = 1'b1;
                cmd_empty = (span_w == '0) || (span_h == '0);
`else
                cmd_ok = (w_e != '0) && (h_e != '0) &&
                         (x1_e + w_e <= W_C) && (x2_e + w_e <= W_C) &&
                         (y1_e + h_e <= H_C) && (y2_e + h_e <= H_C);
                span_w = w_e;
                span_h = h_e;
`endif
            end
            default: ;
        endcase
        last_w = span_w - X_ONE;
        last_h = span_h - Y_ONE;
    end

    // Spans never exceed the screen, so the top bit of the last-offset is dead.
    logic unused_span_msb;
    assign unused_span_msb = &{1'b0, last_w[XW], last_h[YW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            val_q    <= '0;
            rd_cap_q <= '0;
            src_x_q  <= '0;
            src_y_q  <= '0;
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            lat_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            op_q     <= op_d;
            val_q    <= val_d;
            rd_cap_q <= rd_cap_d;
            src_x_q  <= src_x_d;
            src_y_q  <= src_y_d;
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            lat_q    <= lat_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        val_d    = val_q;
        rd_cap_d = rd_cap_q;
        src_x_d  = src_x_q;
        src_y_d  = src_y_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        off_x_d  = off_x_q;
        off_y_d  = off_y_q;
        lat_d    = lat_q;
        done_d   = 1'b0;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_ok) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        error_d  = 1'b0;
                        op_d     = cmd_op;
                        val_d    = cmd_value;
                        src_x_d  = cmd_x1;
                        src_y_d  = cmd_y1;
                        dst_x_d  = base_dx;
                        dst_y_d  = base_dy;
                        last_x_d = last_w[XW-1:0];
                        last_y_d = last_h[YW-1:0];
                        off_x_d  = '0;
                        off_y_d  = '0;
                        if (cmd_empty)             done_d  = 1'b1;
                        else if (cmd_op == OP_FILL) state_d = S_WR;
                        else                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    rd_cap_d = mem_rd_data;
                    state_d  = S_WR;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_WR: begin
                state_d = (op_q == OP_FILL) ? S_WR : S_RD;
                if (off_x_q == last_x_q) begin
                    off_x_d = '0;
                    if (off_y_q == last_y_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        off_y_d = off_y_q + YW'(1);
                    end
                end else begin
                    off_x_d = off_x_q + XW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and address decode straight from state so reset drops them at once.
    always_comb begin
        mem_x       = '0;
        mem_y       = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            S_RD: begin
                mem_rd_en = 1'b1;
                mem_x     = src_x_q + off_x_q;
                mem_y     = src_y_q + off_y_q;
            end
            S_WR: begin
                mem_wr_en = 1'b1;
                mem_x     = dst_x_q + off_x_q;
                mem_y     = dst_y_q + off_y_q;
                case (op_q)
                    OP_FILL: mem_wr_data = val_q;
                    OP_XOR:  mem_wr_data = rd_cap_q ^ val_q;
                    default: mem_wr_data = rd_cap_q;
                endcase
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_gpu_raster_engine.sv
//------------------------------------------------------------------------------
// tb_gpu_raster_engine : directed + random commands against a pixel-array reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gpu_raster_engine;

    localparam int W  = 320;
    localparam int H  = 200;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int PW = 4;
    localparam int RL = 2;
    localparam int LIMIT = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] cmd_x1, cmd_x2, cmd_w;
    logic [YW-1:0] cmd_y1, cmd_y2, cmd_h;
    logic [PW-1:0] cmd_value;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic          mem_rd_en, mem_wr_en;
    logic [PW-1:0] mem_wr_data, mem_rd_data;
    logic          busy, done, error;

    int checks   = 0;
    int failures = 0;
    int n_cmds   = 0;

    gpu_raster_engine #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .PW(PW), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
        .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_value(cmd_value),
        .mem_x(mem_x), .mem_y(mem_y), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic int pat(input int i);
        return (i * 13 + (i >> 4)) & ((1 << PW) - 1);
    endfunction

    // Framebuffer RAM: operates on the falling edge, read data appears RL cycles after the strobe.
    logic [PW-1:0] ram     [W*H];
    logic [PW-1:0] ref_mem [W*H];
    logic [PW-1:0] pipe_d  [RL+1];
    logic          pipe_v  [RL+1];
    logic [PW-1:0] junk;
    logic          ram_init = 1'b0;

    always @(negedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < W*H; i++) ram[i] <= PW'(pat(i));
            for (int k = 0; k <= RL; k++) pipe_v[k] <= 1'b0;
            ram_init <= 1'b1;
        end else begin
            if (mem_wr_en && (int'(mem_y) * W + int'(mem_x)) < W*H)
                ram[int'(mem_y) * W + int'(mem_x)] <= mem_wr_data;
            pipe_v[0] <= mem_rd_en;
            pipe_d[0] <= ((int'(mem_y) * W + int'(mem_x)) < W*H) ? ram[int'(mem_y) * W + int'(mem_x)] : '0;
            for (int k = 1; k <= RL; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
        junk <= PW'($urandom);
    end
    assign mem_rd_data = pipe_v[RL] ? pipe_d[RL] : junk;

    typedef struct { int x; int y; int d; } acc_t;
    acc_t wq[$], rq[$], ewq[$], erq[$];
    int done_n = 0, overlap_n = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) wq.push_back('{x: int'(mem_x), y: int'(mem_y), d: int'(mem_wr_data)});
            if (mem_rd_en) rq.push_back('{x: int'(mem_x), y: int'(mem_y), d: 0});
            if (mem_wr_en && mem_rd_en) overlap_n++;
            if (done) done_n++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: decide validity and effective region, then walk it pixel by pixel.
    task automatic model_cmd(input int op, x1, y1, x2, y2, w, h, val,
                             output int err, output int npix);
        int ew, eh, dx0, dy0, s, d, nd;
        err = 0; npix = 0; ew = 0; eh = 0; dx0 = x1; dy0 = y1;
        ewq.delete(); erq.delete();
        if (op == 3) begin
            err = 1;
        end else if (op < 2) begin
`ifdef GPU_RASTER_CLIP_EN
            ew = imin(x2, W-1) - x1 + 1;
            eh = imin(y2, H-1) - y1 + 1;
`else
            if (!(x1 <= x2 && x2 < W && y1 <= y2 && y2 < H)) err = 1;
            ew = x2 - x1 + 1;
            eh = y2 - y1 + 1;
`endif
        end else begin
            dx0 = x2; dy0 = y2;
`ifdef GPU_RASTER_CLIP_EN
            ew = imin(w, imin(W - x1, W - x2));
            eh = imin(h, imin(H - y1, H - y2));
`else
            if (!(w >= 1 && h >= 1 && x1 + w <= W && x2 + w <= W && y1 + h <= H && y2 + h <= H)) err = 1;
            ew = w; eh = h;
`endif
        end
        if (err == 0) begin
            for (int r = 0; r < eh; r++) begin
                for (int c = 0; c < ew; c++) begin
                    s  = (y1 + r) * W + (x1 + c);
                    d  = (dy0 + r) * W + (dx0 + c);
                    nd = (op == 0) ? val : (op == 1) ? (int'(ref_mem[s]) ^ val) : int'(ref_mem[s]);
                    if (op != 0) erq.push_back('{x: x1 + c, y: y1 + r, d: 0});
                    ewq.push_back('{x: dx0 + c, y: dy0 + r, d: nd});
                    ref_mem[d] = PW'(nd);
                    npix++;
                end
            end
        end
    endtask

    task automatic issue(input int op, x1, y1, x2, y2, w, h, val);
        @(negedge clk);
        cmd_op = 2'(op); cmd_x1 = XW'(x1); cmd_y1 = YW'(y1); cmd_x2 = XW'(x2); cmd_y2 = YW'(y2);
        cmd_w = XW'(w); cmd_h = YW'(h); cmd_value = PW'(val); cmd_valid = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_x1 = XW'($urandom); cmd_y1 = YW'($urandom);
        cmd_x2 = XW'($urandom); cmd_y2 = YW'($urandom); cmd_w = XW'($urandom);
        cmd_h = YW'($urandom); cmd_value = PW'($urandom);
    endtask

    task automatic run_cmd(input int op, x1, y1, x2, y2, w, h, val);
        int err, npix, cyc, k, busy_n, wb, rb, ov0, mism;
        bit seen;
        model_cmd(op, x1, y1, x2, y2, w, h, val & ((1 << PW) - 1), err, npix);
        cyc = (op == 0) ? 1 : RL + 2;
        wb = wq.size(); rb = rq.size(); ov0 = overlap_n;
        n_cmds++;
        issue(op, x1, y1, x2, y2, w, h, val);
        @(negedge clk);
        if (npix > 0) chk("first_strobe", int'(mem_rd_en | mem_wr_en), 1);
        k = 1; busy_n = 0; seen = 0;
        while (!seen && k < LIMIT) begin
            if (done) seen = 1;
            else begin
                busy_n += int'(busy);
                @(negedge clk);
                k++;
            end
        end
        chk("done_seen", int'(seen), 1);
        chk("done_latency", k, npix * cyc + 1);
        chk("busy_cycles", busy_n, npix * cyc);
        chk("error_flag", error, err);
        chk("ready_at_done", cmd_ready, 1);
        chk("wr_count", wq.size() - wb, ewq.size());
        mism = 0;
        for (int i = 0; i < ewq.size(); i++)
            if (wb + i >= wq.size() || wq[wb+i].x != ewq[i].x || wq[wb+i].y != ewq[i].y || wq[wb+i].d != ewq[i].d)
                mism++;
        chk("wr_sequence", mism, 0);
        chk("rd_count", rq.size() - rb, erq.size());
        mism = 0;
        for (int i = 0; i < erq.size(); i++)
            if (rb + i >= rq.size() || rq[rb+i].x != erq[i].x || rq[rb+i].y != erq[i].y)
                mism++;
        chk("rd_sequence", mism, 0);
        chk("rd_wr_overlap", overlap_n - ov0, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int op, x1, y1, x2, y2, w, h, mism, d0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x1 = '0; cmd_y1 = '0;
        cmd_x2 = '0; cmd_y2 = '0; cmd_w = '0; cmd_h = '0; cmd_value = '0;
        for (int i = 0; i < W*H; i++) ref_mem[i] = PW'(pat(i));
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", int'(mem_x) + int'(mem_y), 0);
        chk("rst_wr_data", mem_wr_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(0, 2, 3, 4, 3, 0, 0, 1);
        run_cmd(0, 0, 0, 0, 0, 0, 0, 1);
        run_cmd(0, 1, 0, 1, 0, 0, 0, 0);
        run_cmd(1, 0, 0, 1, 0, 0, 0, 1);
        run_cmd(2, 10, 10, 20, 5, 2, 2, 0);
        run_cmd(0, 5, 0, 4, 0, 0, 0, 3);
        run_cmd(3, 1, 1, 2, 2, 1, 1, 1);
        run_cmd(0, 7, 7, 9, 8, 0, 0, 2);
        run_cmd(0, 318, 0, 330, 0, 0, 0, 5);
        run_cmd(2, 316, 0, 0, 199, 4, 1, 0);
        run_cmd(2, 0, 0, 0, 0, 0, 1, 0);
        run_cmd(1, 0, 199, 319, 199, 0, 0, 9);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            w = 0; h = 0;
            if (op <= 4) begin
                op = (op <= 2) ? 0 : 1;
                x1 = $urandom_range(0, W + 2);
                y1 = $urandom_range(0, H + 2);
                x2 = x1 + $urandom_range(0, 4) - (($urandom_range(0, 9) == 0) ? 1 : 0);
                y2 = y1 + $urandom_range(0, 3) - (($urandom_range(0, 9) == 0) ? 1 : 0);
                if (x2 < 0) x2 = 0;
                if (y2 < 0) y2 = 0;
            end else if (op <= 6) begin
                op = 2;
                x1 = ($urandom_range(0, 3) == 0) ? W - $urandom_range(1, 4) : $urandom_range(0, W - 1);
                y1 = $urandom_range(0, H - 1);
                x2 = $urandom_range(0, W - 1);
                y2 = ($urandom_range(0, 3) == 0) ? H - $urandom_range(1, 4) : $urandom_range(0, H - 1);
                w = $urandom_range(0, 4);
                h = $urandom_range(0, 4);
            end else begin
                op = 3;
                x1 = $urandom_range(0, 50); y1 = $urandom_range(0, 50);
                x2 = x1; y2 = y1; w = 1; h = 1;
            end
            run_cmd(op, x1, y1, x2, y2, w, h, $urandom_range(0, 15));
        end

        chk("done_pulse_total", done_n, n_cmds);
        mism = 0;
        for (int i = 0; i < W*H; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("framebuffer_contents", mism, 0);

        // Abort a long COPY part-way through.
        issue(2, 50, 50, 100, 60, 4, 4, 0);
        repeat (7) @(negedge clk);
        chk("busy_mid_copy", busy, 1);
        d0 = done_n;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_addr", int'(mem_x) + int'(mem_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_n - d0, 0);
        chk("abort_ready_after", cmd_ready, 1);
        chk("abort_error", error, 0);

        run_cmd(0, 100, 190, 103, 191, 0, 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
